// File: rtl/pipe_mux_n_pkg.sv
// -----------------------------------------------------------------------------
// pipe_mux_n_pkg
// Core-wide constants shared by the registered select muxes and their
// handshake logic.
//   MUX_DEFAULT_WIDTH : default datapath width of a mux channel
//   MUX_MODE_SEL      : rr_en value selecting explicit-select grant
//   MUX_MODE_RR       : rr_en value selecting round-robin grant
// -----------------------------------------------------------------------------
package pipe_mux_n_pkg;

  localparam int MUX_DEFAULT_WIDTH = 32;

  localparam logic MUX_MODE_SEL = 1'b0;
  localparam logic MUX_MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n
// Purely combinational rotating-priority search. Starting at ptr and wrapping
// past N-1 back to 0, the first requesting channel wins.
// Ports:
//   req       in  N      per-channel request
//   ptr       in  SEL_W  highest-priority channel index (must be < N)
//   gnt_valid out 1      some channel is granted
//   gnt_idx   out SEL_W  granted channel index (0 when gnt_valid=0)
// -----------------------------------------------------------------------------
module rr_arbiter_n
  import pipe_mux_n_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

  // Bit k of w_rot is the request of channel (ptr + k) mod N, so the lowest
  // set bit is the winner of the rotating search.
  logic [N-1:0] w_rot;
  logic [SEL_W:0] w_sum;

  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_sum     = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && w_rot[k]) begin
        w_sum = {1'b0, ptr} + (SEL_W+1)'(k);
        if (w_sum >= N_L) begin
          w_sum = w_sum - N_L;
        end
        gnt_valid = 1'b1;
        gnt_idx   = w_sum[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// -----------------------------------------------------------------------------
// pipe_mux_n
// Registered N-to-1 mux with valid/ready on every input and on the output.
// Grant is either an explicit channel select or round-robin arbitration.
// One output register; sustains one word per cycle.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   d_flat     in   N*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready (combinational, one-hot or 0)
//   select     in   SEL_W    channel used when rr_en=0
//   rr_en      in   1        1 = round-robin, 0 = explicit select
//   out_data   out  WIDTH    registered data
//   out_chan   out  SEL_W    registered source channel of out_data
//   out_valid  out  1        registered valid
//   out_ready  in   1        sink accepts the output word
// -----------------------------------------------------------------------------
module pipe_mux_n
  import pipe_mux_n_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] d_flat,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   select,
  input  logic               rr_en,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SEL_W:0]   N_L  = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N-1);

  logic [WIDTH-1:0] r_data_p0;
  logic [SEL_W-1:0] r_chan_p0;
  logic             r_vld_p0;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_accept;
  logic             w_sel_hit;
  logic             w_rr_valid;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_gnt_valid;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;
  logic [SEL_W-1:0] w_ptr_next;

  // ---- grant stage (combinational) ----
  assign w_accept = out_ready | ~r_vld_p0;

  // A select beyond N-1 shifts the one-hot mask out of range and never grants.
  assign w_sel_hit = ({1'b0, select} < N_L) && (|(in_valid & (N'(1) << select)));

  rr_arbiter_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_rr_valid),
    .gnt_idx   (w_rr_idx)
  );

  assign w_gnt_valid = (rr_en == MUX_MODE_RR) ? w_rr_valid : w_sel_hit;
  assign w_gnt_idx   = (rr_en == MUX_MODE_RR) ? w_rr_idx   : select;

  assign in_ready = (rst_n && w_accept && w_gnt_valid) ? (N'(1) << w_gnt_idx) : '0;
  assign w_xfer   = |(in_valid & in_ready);

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_gnt_data = d_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == LAST) ? '0 : w_gnt_idx + SEL_W'(1);

  // ---- output register stage p0 ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_p0 <= '0;
      r_chan_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      if (w_xfer) begin
        r_data_p0 <= w_gnt_data;
        r_chan_p0 <= w_gnt_idx;
        r_vld_p0  <= 1'b1;
      end else if (out_ready) begin
        r_vld_p0  <= 1'b0;
      end
      if (w_xfer && (rr_en == MUX_MODE_RR)) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign out_data  = r_data_p0;
  assign out_chan  = r_chan_p0;
  assign out_valid = r_vld_p0;

endmodule

// File: tb/tb_pipe_mux_n.sv
module tb_pipe_mux_n;

  localparam int WA = 32;
  localparam int NA = 4;
  localparam int WB = 8;
  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [NA*WA-1:0] d_a;
  logic [NA-1:0]    v_a;
  logic [NA-1:0]    rdy_a;
  logic [1:0]       sel_a;
  logic             rr_a;
  logic [WA-1:0]    od_a;
  logic [1:0]       oc_a;
  logic             ov_a;
  logic             ordy_a;

  logic [NB*WB-1:0] d_b;
  logic [NB-1:0]    v_b;
  logic [NB-1:0]    rdy_b;
  logic [1:0]       sel_b;
  logic             rr_b;
  logic [WB-1:0]    od_b;
  logic [1:0]       oc_b;
  logic             ov_b;
  logic             ordy_b;

  pipe_mux_n #(.WIDTH(WA), .N(NA)) u_a (
    .clk(clk), .rst_n(rst_n), .d_flat(d_a), .in_valid(v_a), .in_ready(rdy_a),
    .select(sel_a), .rr_en(rr_a), .out_data(od_a), .out_chan(oc_a),
    .out_valid(ov_a), .out_ready(ordy_a)
  );

  pipe_mux_n #(.WIDTH(WB), .N(NB)) u_b (
    .clk(clk), .rst_n(rst_n), .d_flat(d_b), .in_valid(v_b), .in_ready(rdy_b),
    .select(sel_b), .rr_en(rr_b), .out_data(od_b), .out_chan(oc_b),
    .out_valid(ov_b), .out_ready(ordy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural grant: explicit select or first valid channel scanning
  // ptr, ptr+1, ... modulo n. Returns -1 when nothing is granted.
  function automatic int mgrant(int n, logic [3:0] v, int sel, bit rr, int ptr);
    if (!rr) begin
      if (sel < n && v[sel]) return sel;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  // Model state per instance
  bit            ma_vld, mb_vld;
  logic [WA-1:0] ma_data;
  logic [WB-1:0] mb_data;
  int            ma_chan, mb_chan, ma_ptr, mb_ptr;
  int            ga, gb;

  always_comb ga = mgrant(NA, v_a, int'(sel_a), rr_a, ma_ptr);
  always_comb gb = mgrant(NB, {1'b0, v_b}, int'(sel_b), rr_b, mb_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      ma_vld <= 1'b0; ma_data <= '0; ma_chan <= 0; ma_ptr <= 0;
    end else if ((ordy_a || !ma_vld) && ga >= 0) begin
      ma_data <= d_a[ga*WA +: WA];
      ma_chan <= ga;
      ma_vld  <= 1'b1;
      if (rr_a) ma_ptr <= (ga + 1) % NA;
    end else if (ordy_a) begin
      ma_vld <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mb_vld <= 1'b0; mb_data <= '0; mb_chan <= 0; mb_ptr <= 0;
    end else if ((ordy_b || !mb_vld) && gb >= 0) begin
      mb_data <= d_b[gb*WB +: WB];
      mb_chan <= gb;
      mb_vld  <= 1'b1;
      if (rr_b) mb_ptr <= (gb + 1) % NB;
    end else if (ordy_b) begin
      mb_vld <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] er;
      er = '0;
      if (rst_n && (ordy_a || !ma_vld) && ga >= 0) er = 64'(1) << ga;
      chk("a_in_ready", 64'(rdy_a), er);
      chk("a_out_valid", 64'(ov_a), 64'(ma_vld));
      chk("a_out_data", 64'(od_a), 64'(ma_data));
      chk("a_out_chan", 64'(oc_a), 64'(ma_chan));
      er = '0;
      if (rst_n && (ordy_b || !mb_vld) && gb >= 0) er = 64'(1) << gb;
      chk("b_in_ready", 64'(rdy_b), er);
      chk("b_out_valid", 64'(ov_b), 64'(mb_vld));
      chk("b_out_data", 64'(od_b), 64'(mb_data));
      chk("b_out_chan", 64'(oc_b), 64'(mb_chan));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WA-1:0] da [NA];

  initial begin
    da = '{32'h10, 32'h11, 32'h22, 32'h13};
    rst_n = 1'b0;
    for (int i = 0; i < NA; i++) d_a[i*WA +: WA] = da[i];
    for (int i = 0; i < NB; i++) d_b[i*WB +: WB] = WB'(8'hA0 + i);
    v_a = '0; sel_a = '0; rr_a = 1'b0; ordy_a = 1'b0;
    v_b = '0; sel_b = '0; rr_b = 1'b0; ordy_b = 1'b0;
    step();
    chk_en = 1'b1;
    chk("reset_ov", 64'(ov_a), 64'd0);
    step();
    rst_n = 1'b1;

    // Explicit select, channel 2
    rr_a = 1'b0; sel_a = 2'd2; v_a = 4'hF; ordy_a = 1'b1;
    #1 chk("sel_ready", 64'(rdy_a), 64'b0100);
    step();
    chk("sel_data", 64'(od_a), 64'h22);
    chk("sel_chan", 64'(oc_a), 64'd2);
    chk("sel_valid", 64'(ov_a), 64'd1);
    for (int k = 0; k < 8; k++) begin
      d_a[2*WA +: WA] = WA'(32'h100 + k);
      step();
      chk("sustain_data", 64'(od_a), 64'(32'h100 + k));
    end

    // Backpressure
    d_a[2*WA +: WA] = 32'h22;
    step();
    ordy_a = 1'b0; d_a[2*WA +: WA] = 32'h33;
    #1 chk("stall_ready", 64'(rdy_a), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_data", 64'(od_a), 64'h22);
      chk("stall_valid", 64'(ov_a), 64'd1);
    end
    ordy_a = 1'b1;
    #1 chk("release_ready", 64'(rdy_a), 64'b0100);
    step();
    chk("release_data", 64'(od_a), 64'h33);

    // Drain: no valid input, output empties but data holds
    v_a = '0;
    step();
    chk("drain_valid", 64'(ov_a), 64'd0);
    chk("drain_data", 64'(od_a), 64'h33);

    // Reset mid-stream
    v_a = 4'hF; d_a[2*WA +: WA] = 32'hDEADBEEF;
    step();
    chk("pre_rst_data", 64'(od_a), 64'hDEADBEEF);
    rst_n = 1'b0;
    #1 chk("rst_ready", 64'(rdy_a), 64'd0);
    step();
    chk("rst_valid", 64'(ov_a), 64'd0);
    chk("rst_data", 64'(od_a), 64'd0);
    chk("rst_chan", 64'(oc_a), 64'd0);
    rst_n = 1'b1;
    d_a[2*WA +: WA] = 32'h22;

    // Round-robin fairness
    rr_a = 1'b1; v_a = 4'hF; ordy_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_chan", 64'(oc_a), 64'(k % 4));
      chk("rr_data", 64'(od_a), 64'(da[k % 4]));
    end

    // Skip and wrap: move pointer to 1, then only channels 0 and 3 valid
    step();
    chk("rr_pre_chan", 64'(oc_a), 64'd0);
    v_a = 4'b1001;
    #1 chk("rr_skip_ready", 64'(rdy_a), 64'b1000);
    step();
    chk("rr_skip_chan", 64'(oc_a), 64'd3);
    step();
    chk("rr_wrap_chan", 64'(oc_a), 64'd0);

    // Pointer (now 1) held across explicit-select transfers
    v_a = 4'hF; rr_a = 1'b0; sel_a = 2'd3;
    step();
    chk("sel3_chan", 64'(oc_a), 64'd3);
    rr_a = 1'b1;
    step();
    chk("rr_resume_chan", 64'(oc_a), 64'd1);

    // Mode change during a stall leaves the held word alone
    ordy_a = 1'b0; rr_a = 1'b0; sel_a = 2'd0;
    step();
    chk("modechg_chan", 64'(oc_a), 64'd1);
    chk("modechg_data", 64'(od_a), 64'h11);
    ordy_a = 1'b1; v_a = '0;
    step();

    // N=3: out-of-range select never grants
    sel_b = 2'd3; v_b = 3'b111; rr_b = 1'b0; ordy_b = 1'b1;
    #1 chk("n3_sel3_ready", 64'(rdy_b), 64'd0);
    step();
    chk("n3_sel3_valid", 64'(ov_b), 64'd0);
    step();
    chk("n3_sel3_valid2", 64'(ov_b), 64'd0);
    rr_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("n3_rr_chan", 64'(oc_b), 64'(k % 3));
      chk("n3_rr_data", 64'(od_b), 64'(8'hA0 + (k % 3)));
    end
    v_b = '0;
    step();
    step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised, registered N-to-1 datapath multiplexer with valid/ready handshake on every input channel and on the output.
- Next generation of the core's combinational 32-bit 4:1 select muxes. Used where a mux output must be registered (writeback/forwarding source select, multi-source bus arbitration) or several sources compete for one sink.
- Two grant modes:
  - Explicit select: behaves like a classic mux.
  - Round-robin arbitration.
- One output pipeline register; sustains one transfer per cycle.

Parameters:
- WIDTH, 32: data width per channel in bits; must be >= 1.
- N, 4: number of input channels; must be >= 2; need not be a power of two.
- SEL_W, $clog2(N): select/channel-index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- d_flat  input  N*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- select  input  SEL_W  channel index used when rr_en=0.
- rr_en  input  1  1 = round-robin grant; 0 = explicit select.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  index of the channel that supplied out_data; registered.
- out_valid  output  1  output holds a valid word; registered.
- out_ready  input  1  sink accepts the output word.

Behaviour:
- Reset: rst_n sampled low at posedge clk sets out_valid=0, out_data=0, out_chan=0, rr_ptr=0. While rst_n=0, in_ready is forced to all zeros. No asynchronous path exists.
- Slot free: accept = out_ready | ~out_valid.
- Grant, rr_en=0:
  - g = select, when select < N and in_valid[select]=1.
  - Otherwise no grant. Out-of-range select (non-power-of-two N) never grants.
- Grant, rr_en=1:
  - g = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1.
  - No valid channel: no grant.
- in_ready[i] = rst_n & accept & granted & (i == g). At most one bit set. in_ready never depends on in_valid of the same channel beyond the grant decision.
- Transfer in (some in_valid[i] & in_ready[i] at a posedge): out_data <= channel g data, out_chan <= g, out_valid <= 1.
- Otherwise, if out_ready=1: out_valid <= 0; out_data and out_chan hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid are held stable, and all in_ready bits are 0.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k.
- Simultaneous out_ready=1 and new transfer in: the output word is replaced in the same edge, giving full throughput of 1 word/cycle.
- rr_ptr:
  - Updated only on a transfer in while rr_en=1: rr_ptr <= (g == N-1) ? 0 : g+1.
  - Held otherwise, including while rr_en=0.
- Mode change: rr_en and select are purely combinational into grant and take effect the same cycle. Changing either while stalled does not alter the held output word.
- Sources must hold data and valid until accepted. The block does not check this.

Decomposition:
- Shared package (core-wide mux/handshake constants):
  - Default WIDTH=32.
  - Mode encoding constants MUX_MODE_SEL=1'b0, MUX_MODE_RR=1'b1.
- One natural sub-module: rr_arbiter_n.
  - Parameter N.
  - Inputs req[N], ptr[SEL_W].
  - Outputs gnt_valid, gnt_idx.
  - Purely combinational rotating priority search.
  - pipe_mux_n owns rr_ptr and the output register.

Test Plan:
- Reset mid-stream: out_valid=1, out_data=0xDEADBEEF, then rst_n=0 for one edge -> out_valid=0, out_data=0, out_chan=0, in_ready=0000 while rst_n=0.
- Explicit select, N=4: rr_en=0, select=2, in_valid=1111, d2=0x00000022, out_ready=1 -> in_ready=0100; one cycle later out_data=0x22, out_chan=2, out_valid=1; one word per cycle sustained over 8 cycles.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while d2 changes to 0x33 -> out_data stays 0x22 and in_ready=0000. Release out_ready -> 0x33 follows on the next edge.
- Round-robin fairness: rr_en=1, in_valid=1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
- Round-robin skip and wrap: in_valid=1001, rr_ptr=1 -> grant channel 3, then rr_ptr wraps to 0 and the next grant is channel 0.
- Non-power-of-two N=3: select=3 with all valid -> in_ready=000 and out_valid stays 0. rr_en=1 -> out_chan sequence 0,1,2,0.
